// File: rtl/dtube_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment tube.
// Round-robin digit slots with a blank gap at the start of each slot,
// frame-aligned display updates via valid/ready, and per-digit blinking.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_BLANK | leading gap of a slot, all digits off (anti-ghosting)
// S_DRIVE | digit_idx selected, its segment code on the bus
module dtube_scan_ctrl #(
   parameter int DIGIT_CYCLES = 12500,
   parameter int BLANK_CYCLES = 250,
   parameter int BLINK_FRAMES = 250
) (
   input  logic        sys_clk_i,
   input  logic        all_reset,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [15:0] upd_digits,
   input  logic [3:0]  upd_dp,
   input  logic [3:0]  upd_blink,
   output logic [3:0]  dtube_cs_n,
   output logic [7:0]  dtube_data,
   output logic        frame_done
);

   localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DRIVE_LOAD = CW'(DIGIT_CYCLES - BLANK_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES - 1);

   typedef enum logic {S_BLANK, S_DRIVE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    digit_idx;
   logic [15:0]   disp_digits;
   logic [3:0]    disp_dp;
   logic [3:0]    disp_blink;
   logic [15:0]   pend_digits;
   logic [3:0]    pend_dp;
   logic [3:0]    pend_blink;
   logic          blink_phase;
   logic [BW-1:0] blink_cnt;
   logic [7:0]    drive_data;
   logic [3:0]    drive_cs_n;

   // Active-low segment pattern {dp,g,f,e,d,c,b,a} with dp off.
   function automatic logic [7:0] seg_code(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Bus values for the digit about to be driven; blinking hides dp too.
   always_comb begin
      drive_data = seg_code(disp_digits[{digit_idx, 2'b00} +: 4]);
      if (disp_dp[digit_idx])
         drive_data[7] = 1'b0;
      if (blink_phase && disp_blink[digit_idx])
         drive_data = 8'hFF;
      drive_cs_n = ~(4'b0001 << digit_idx);
   end

   // Scan FSM, handshake, frame-boundary update and blink timing.
   always_ff @(posedge sys_clk_i or negedge all_reset) begin
      if (!all_reset) begin
         state       <= S_BLANK;
         cnt         <= BLANK_LOAD;
         digit_idx   <= 2'd0;
         dtube_cs_n  <= 4'hF;
         dtube_data  <= 8'hFF;
         frame_done  <= 1'b0;
         upd_ready   <= 1'b1;
         disp_digits <= 16'h0000;
         disp_dp     <= 4'h0;
         disp_blink  <= 4'h0;
         pend_digits <= 16'h0000;
         pend_dp     <= 4'h0;
         pend_blink  <= 4'h0;
         blink_phase <= 1'b0;
         blink_cnt   <= BLINK_LOAD;
      end else begin
         frame_done <= 1'b0;

         // upd_ready low doubles as "pending full", so an accept can never
         // coincide with the boundary transfer below.
         if (upd_valid && upd_ready) begin
            pend_digits <= upd_digits;
            pend_dp     <= upd_dp;
            pend_blink  <= upd_blink;
            upd_ready   <= 1'b0;
         end

         case (state)
            S_BLANK: begin
               if (cnt == '0) begin
                  state      <= S_DRIVE;
                  cnt        <= DRIVE_LOAD;
                  dtube_cs_n <= drive_cs_n;
                  dtube_data <= drive_data;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               if (cnt == '0) begin
                  state      <= S_BLANK;
                  cnt        <= BLANK_LOAD;
                  digit_idx  <= digit_idx + 2'd1;
                  dtube_cs_n <= 4'hF;
                  dtube_data <= 8'hFF;
                  if (digit_idx == 2'd3) begin
                     frame_done <= 1'b1;
                     if (blink_cnt == '0) begin
                        blink_cnt   <= BLINK_LOAD;
                        blink_phase <= ~blink_phase;
                     end else begin
                        blink_cnt <= blink_cnt - 1'b1;
                     end
                     if (!upd_ready) begin
                        disp_digits <= pend_digits;
                        disp_dp     <= pend_dp;
                        disp_blink  <= pend_blink;
                        upd_ready   <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule
